// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator (off/on/blink/one-shot pulse)
//
// Purpose: a free-running prescaler produces a timebase tick every TICK_DIV
// clocks. Each of NUM_CH channels runs its own mode (OFF, ON, BLINK, PULSE)
// against that shared tick, using a per-channel period and counter.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   wr_en      - channel configuration write strobe
//   wr_ch      - target channel; writes to channels >= NUM_CH are dropped
//   wr_mode    - 0 OFF, 1 ON, 2 BLINK, 3 PULSE
//   wr_period  - period in ticks minus one
//   led        - registered LED drive, one bit per channel
//   pulse_done - one-cycle strobe per channel when a PULSE completes

module led_pattern_gen #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 27,
  parameter int TICK_DIV = 100_000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [CNT_W-1:0]  wr_period,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] pulse_done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  logic [PS_W-1:0]   ps_q, ps_d;
  logic              tick;

  logic [1:0]        mode_q   [NUM_CH];
  logic [1:0]        mode_d   [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;
  logic [NUM_CH-1:0] done_q, done_d;

  logic              wr_valid;

  // With TICK_DIV = 1 PS_LAST is 0, so the prescaler sits at 0 and tick is
  // high every cycle.
  assign tick     = (ps_q == PS_LAST);
  assign ps_d     = tick ? '0 : ps_q + PS_W'(1);
  assign wr_valid = wr_en && (int'(wr_ch) < NUM_CH);

  // Next-state logic. A write to a channel takes priority over a tick in the
  // same cycle, which is also what silently aborts a PULSE in progress.
  always_comb begin
    led_d  = led_q;
    done_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mode_d[ch]   = mode_q[ch];
      period_d[ch] = period_q[ch];
      count_d[ch]  = count_q[ch];
      if (wr_valid && (int'(wr_ch) == ch)) begin
        mode_d[ch]   = wr_mode;
        period_d[ch] = wr_period;
        count_d[ch]  = '0;
        led_d[ch]    = (wr_mode != MODE_OFF);
      end else if (tick) begin
        case (mode_q[ch])
          MODE_BLINK: begin
            if (count_q[ch] == period_q[ch]) begin
              count_d[ch] = '0;
              led_d[ch]   = ~led_q[ch];
            end else begin
              count_d[ch] = count_q[ch] + CNT_W'(1);
            end
          end
          MODE_PULSE: begin
            if (count_q[ch] == period_q[ch]) begin
              count_d[ch] = '0;
              mode_d[ch]  = MODE_OFF;
              led_d[ch]   = 1'b0;
              done_d[ch]  = 1'b1;
            end else begin
              count_d[ch] = count_q[ch] + CNT_W'(1);
            end
          end
          default: ;  // OFF and ON hold their state
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      led_q  <= '0;
      done_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch]   <= MODE_OFF;
        period_q[ch] <= '0;
        count_q[ch]  <= '0;
      end
    end else begin
      ps_q   <= ps_d;
      led_q  <= led_d;
      done_q <= done_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch]   <= mode_d[ch];
        period_q[ch] <= period_d[ch];
        count_q[ch]  <= count_d[ch];
      end
    end
  end

  assign led        = led_q;
  assign pulse_done = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen (4ch/div4 and 3ch/div1 instances)
module tb_led_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_wr_en;
  logic [1:0] a_wr_ch, a_wr_mode;
  logic [7:0] a_wr_period;
  logic [3:0] a_led, a_done;
  logic       b_wr_en;
  logic [1:0] b_wr_ch, b_wr_mode;
  logic [7:0] b_wr_period;
  logic [2:0] b_led, b_done;

  led_pattern_gen #(.NUM_CH(4), .CNT_W(8), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_ch(a_wr_ch), .wr_mode(a_wr_mode),
    .wr_period(a_wr_period), .led(a_led), .pulse_done(a_done)
  );

  led_pattern_gen #(.NUM_CH(3), .CNT_W(8), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_mode(b_wr_mode),
    .wr_period(b_wr_period), .led(b_led), .pulse_done(b_done)
  );

  // Reference model: per channel only the last accepted write (mode, period,
  // edge index) is kept; outputs are derived from how many ticks have elapsed.
  int     md [2][4];
  int     pr [2][4];
  longint wt [2][4];
  int     td  [2] = '{4, 1};
  int     nch [2] = '{4, 3};
  longint edge_k;

  int vectors = 0;
  int miscompares = 0;
  logic [13:0] exp_q[$];

  function automatic longint ticks_between(longint a, longint b, int d);
    return (b + 1) / d - (a + 1) / d;
  endfunction

  // returns {led, pulse_done} after edge t
  function automatic logic [1:0] ch_expect(int d, int c, longint t);
    longint n   = ticks_between(wt[d][c], t, td[d]);
    longint len = longint'(pr[d][c]) + 1;
    case (md[d][c])
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return {((n / len) % 2) == 0, 1'b0};
      default: return {n < len, (n == len) && (((t + 1) % td[d]) == 0)};
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        md[d][c] = 0; pr[d][c] = 0; wt[d][c] = 0;
      end
    edge_k = 0;
  endtask

  task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t: got led_a=%b done_a=%b led_b=%b done_b=%b, want led_a=%b done_a=%b led_b=%b done_b=%b",
               nm, $time, got[13:10], got[9:6], got[5:3], got[2:0],
               want[13:10], want[9:6], want[5:3], want[2:0]);
    end
  endtask

  // Called at a falling edge: drive inputs for the coming rising edge, push
  // the expected outputs after that edge, then advance to the next falling edge.
  task automatic step(input bit aw, input int ac, input int am, input int ap,
                      input bit bw, input int bc, input int bm, input int bp);
    logic [3:0] el_a, ed_a;
    logic [2:0] el_b, ed_b;
    logic [1:0] r;
    a_wr_en = aw; a_wr_ch = 2'(ac); a_wr_mode = 2'(am); a_wr_period = 8'(ap);
    b_wr_en = bw; b_wr_ch = 2'(bc); b_wr_mode = 2'(bm); b_wr_period = 8'(bp);
    if (aw && ac < nch[0]) begin md[0][ac] = am; pr[0][ac] = ap; wt[0][ac] = edge_k; end
    if (bw && bc < nch[1]) begin md[1][bc] = bm; pr[1][bc] = bp; wt[1][bc] = edge_k; end
    for (int c = 0; c < 4; c++) begin
      r = ch_expect(0, c, edge_k); el_a[c] = r[1]; ed_a[c] = r[0];
    end
    for (int c = 0; c < 3; c++) begin
      r = ch_expect(1, c, edge_k); el_b[c] = r[1]; ed_b[c] = r[0];
    end
    exp_q.push_back({el_a, ed_a, el_b, ed_b});
    edge_k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
  endtask

  // Asserts reset a little after a rising edge, checks outputs clear before
  // the next edge, holds it, then releases at a falling edge.
  task automatic mid_cycle_reset();
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_clear", {a_led, a_done, b_led, b_done}, 14'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", {a_led, a_done, b_led, b_done}, 14'h0);
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  // Monitor: compares each rising edge's outputs against the queued expectation.
  initial begin
    logic [13:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", {a_led, a_done, b_led, b_done}, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_wr_en = 0; a_wr_ch = 0; a_wr_mode = 0; a_wr_period = 0;
    b_wr_en = 0; b_wr_ch = 0; b_wr_mode = 0; b_wr_period = 0;
    model_clear();
    #1 chk("reset_state", {a_led, a_done, b_led, b_done}, 14'h0);
    repeat (3) @(negedge clk);
    chk("reset_state_held", {a_led, a_done, b_led, b_done}, 14'h0);
    rst_n = 1'b1;

    // blink ch0 (period 2); B ch0 blinks period 0 at one tick per clock
    step(1, 0, 2, 2, 1, 0, 2, 0);
    idle(3);
    // pulses: A ch1 period 1, B ch1 period 0
    step(1, 1, 3, 1, 1, 1, 3, 0);
    idle(2);
    // A ch3 long pulse, B ch2 ON
    step(1, 3, 3, 5, 1, 2, 1, 0);
    idle(8);
    // abort A ch3 pulse with ON; write to nonexistent B ch3
    step(1, 3, 1, 0, 1, 3, 2, 1);
    idle(30);
    // write A ch2 exactly in a tick cycle while ch0 keeps blinking
    while (((edge_k + 1) % 4) != 0) idle(1);
    step(1, 2, 2, 0, 0, 0, 0, 0);
    idle(20);

    rand_steps(600);

    // catch reset in the middle of a blink and a pulse
    step(1, 0, 2, 3, 1, 0, 2, 2);
    step(1, 1, 3, 7, 1, 1, 3, 9);
    idle(5);
    mid_cycle_reset();

    // first tick after release must land on the 4th edge
    step(1, 0, 2, 0, 1, 0, 3, 2);
    idle(12);
    rand_steps(400);
    idle(4);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
